crc32_stream_engine: RTL and testbench

//   Streaming Ethernet CRC-32 (IEEE 802.3) engine for the MAC TX/RX datapath. Takes a frame as a sequence of

---
 rtl/crc32_stream_engine.sv | 117 +++++++++++
 tb/tb_crc32_stream_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream_engine.sv
// Streaming Ethernet CRC-32 engine: one DATA_WIDTH beat per clock with per-byte keep.
// GEN mode presents the FCS to append; CHK mode flags a good frame via the fixed residue.
module crc32_stream_engine #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter int          CHK_MODE   = 0,
    parameter logic [31:0] RESIDUE    = 32'hC704DD7B,
    localparam int         KEEP_W     = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [KEEP_W-1:0]     i_keep,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [31:0]           o_crc,
    output logic                  o_crc_good,
    output logic                  o_crc_err,
    output logic [15:0]           o_byte_cnt,
    output logic                  o_crc_valid,
    input  logic                  i_crc_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t      state, state_nxt;
    logic [31:0] crc_reg, chain;
    logic [15:0] cnt, pop, cnt_nxt;
    logic [16:0] cnt_sum;
    logic        err_acc, err_nxt, bad_keep, start, acc;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Wire order is LSB-first, so each byte is reversed before the MSB-first shift.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic [7:0]  rb;
        for (int i = 0; i < 8; i++) rb[i] = b[7-i];
        r = c ^ {rb, 24'h0};
        for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    assign acc   = i_valid && o_ready;
    assign start = (state != ACCUM);

    always_comb begin
        chain = crc_reg;
        pop   = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            if (i_keep[k]) chain = crc_byte(chain, i_data[8*k +: 8]);
            pop = pop + 16'(i_keep[k]);
        end
    end

    // Keep must be non-empty, contiguous from byte 0, and full on every non-last beat.
    assign bad_keep = (i_keep == '0) ||
                      ((i_keep & (i_keep + KEEP_W'(1))) != '0) ||
                      (!i_last && (i_keep != '1));
    assign err_nxt  = (start ? 1'b0 : err_acc) | bad_keep;
    assign cnt_sum  = {1'b0, (start ? 16'h0 : cnt)} + {1'b0, pop};
    assign cnt_nxt  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_crc_valid = (state == RESULT);
        o_ready     = !((state == RESULT) && !i_crc_ready);
        case (state)
            IDLE, ACCUM: if (acc) state_nxt = i_last ? RESULT : ACCUM;
            RESULT: if (i_crc_ready) begin
                if (acc) state_nxt = i_last ? RESULT : ACCUM;
                else     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc_reg    <= CRC_INIT;
            cnt        <= '0;
            err_acc    <= 1'b0;
            o_crc      <= '0;
            o_crc_good <= 1'b0;
            o_crc_err  <= 1'b0;
            o_byte_cnt <= '0;
        end else if (acc) begin
            cnt     <= cnt_nxt;
            err_acc <= err_nxt;
            if (i_last) begin
                // Re-preset here so a back-to-back frame starts from a clean register.
                crc_reg    <= CRC_INIT;
                o_crc      <= ~bitrev32(chain);
                o_crc_good <= (CHK_MODE != 0) && (chain == RESIDUE);
                o_crc_err  <= err_nxt;
                o_byte_cnt <= cnt_nxt;
            end else begin
                crc_reg <= chain;
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Directed/table bench for the CRC-32 stream engine: a 32-bit GEN instance and a 64-bit CHK instance,
// compared against a reflected byte-serial LUT model.
module tb_crc32_stream_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] d32 = '0;
    logic [3:0]  k32 = '0;
    logic        v32 = 1'b0, l32 = 1'b0, cr32 = 1'b1;
    logic        rdy32, good32, err32, cv32;
    logic [31:0] crc32o;
    logic [15:0] cnt32;

    logic [63:0] d64 = '0;
    logic [7:0]  k64 = '0;
    logic        v64 = 1'b0, l64 = 1'b0, cr64 = 1'b1;
    logic        rdy64, good64, err64, cv64;
    logic [31:0] crc64o;
    logic [15:0] cnt64;

    crc32_stream_engine #(.DATA_WIDTH(32), .CHK_MODE(0)) u32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(d32), .i_keep(k32), .i_valid(v32), .i_last(l32),
        .o_ready(rdy32), .o_crc(crc32o), .o_crc_good(good32), .o_crc_err(err32), .o_byte_cnt(cnt32),
        .o_crc_valid(cv32), .i_crc_ready(cr32));

    crc32_stream_engine #(.DATA_WIDTH(64), .CHK_MODE(1)) u64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(d64), .i_keep(k64), .i_valid(v64), .i_last(l64),
        .o_ready(rdy64), .o_crc(crc64o), .o_crc_good(good64), .o_crc_err(err64), .o_byte_cnt(cnt64),
        .o_crc_valid(cv64), .i_crc_ready(cr64));

    int ncmp = 0, nfail = 0;
    logic [31:0] tbl [256];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [7:0] q[$]);
        logic [31:0] c;
        c = '1;
        foreach (q[i]) c = tbl[c[7:0] ^ q[i]] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        d32 = d; k32 = k; l32 = l; v32 = 1'b1; n = 0;
        while (!rdy32 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("ready_timeout32", 1, 0);
        @(posedge clk); #1;
        v32 = 1'b0; l32 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        d64 = d; k64 = k; l64 = l; v64 = 1'b1; n = 0;
        while (!rdy64 && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("ready_timeout64", 1, 0);
        @(posedge clk); #1;
        v64 = 1'b0; l64 = 1'b0;
    endtask

    task automatic frame32(input logic [7:0] q[$], input bit gaps);
        logic [31:0] d;
        logic [3:0]  k;
        for (int i = 0; i < q.size(); i += 4) begin
            d = '0; k = '0;
            for (int j = 0; j < 4; j++)
                if (i + j < q.size()) begin d[8*j +: 8] = q[i+j]; k[j] = 1'b1; end
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send32(d, k, (i + 4 >= q.size()));
        end
    endtask

    task automatic frame64(input logic [7:0] q[$], input bit gaps);
        logic [63:0] d;
        logic [7:0]  k;
        for (int i = 0; i < q.size(); i += 8) begin
            d = '0; k = '0;
            for (int j = 0; j < 8; j++)
                if (i + j < q.size()) begin d[8*j +: 8] = q[i+j]; k[j] = 1'b1; end
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send64(d, k, (i + 8 >= q.size()));
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        ccrc;
        logic [31:0] crc;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  s9[$];
        logic [31:0] c, f;
        int          len;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            tbl[i] = c;
        end
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        vt[0]  = '{32'h34333231, 4'hF, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
        vt[1]  = '{32'h38373635, 4'hF, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
        vt[2]  = '{32'h00000039, 4'h1, 1'b1, 1'b1, 32'hCBF43926, 16'd9, 1'b0};
        vt[3]  = '{32'h00000000, 4'h1, 1'b1, 1'b1, 32'hD202EF8D, 16'd1, 1'b0};
        vt[4]  = '{32'h00000000, 4'h5, 1'b1, 1'b0, 32'h0,        16'd2, 1'b1};
        vt[5]  = '{32'h44434241, 4'h7, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
        vt[6]  = '{32'h00000045, 4'h1, 1'b1, 1'b0, 32'h0,        16'd4, 1'b1};
        vt[7]  = '{32'hAAAAAAAA, 4'h0, 1'b1, 1'b1, 32'h00000000, 16'd0, 1'b1};
        vt[8]  = '{32'h34333231, 4'hF, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
        vt[9]  = '{32'h38373635, 4'hF, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
        vt[10] = '{32'h00000039, 4'h1, 1'b1, 1'b1, 32'hCBF43926, 16'd9, 1'b0};

        // reset state
        #2;
        chk("rst_ready", rdy32, 1);
        chk("rst_valid", cv32, 0);
        chk("rst_crc", crc32o, 0);
        chk("rst_cnt", cnt32, 0);
        chk("rst_err", err32, 0);
        chk("rst_good64", good64, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven beats, result consumed every cycle
        foreach (vt[i]) begin
            send32(vt[i].data, vt[i].keep, vt[i].last);
            chk($sformatf("tbl%0d_valid", i), cv32, vt[i].last);
            if (vt[i].last) begin
                if (vt[i].ccrc) chk($sformatf("tbl%0d_crc", i), crc32o, vt[i].crc);
                chk($sformatf("tbl%0d_cnt", i), cnt32, vt[i].cnt);
                chk($sformatf("tbl%0d_err", i), err32, vt[i].err);
                chk($sformatf("tbl%0d_good", i), good32, 0);
            end
        end
        @(posedge clk); #1;
        chk("tbl_consumed", cv32, 0);

        // backpressure: result held, junk beat ignored, next frame starts on consume cycle
        cr32 = 1'b0;
        frame32(s9, 0);
        chk("bp_valid", cv32, 1);
        chk("bp_crc", crc32o, 32'hCBF43926);
        d32 = 32'hDEADBEEF; k32 = 4'hF; l32 = 1'b1; v32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_ready", i), rdy32, 0);
            chk($sformatf("bp%0d_valid", i), cv32, 1);
            chk($sformatf("bp%0d_crc", i), crc32o, 32'hCBF43926);
            chk($sformatf("bp%0d_cnt", i), cnt32, 9);
        end
        d32 = 32'h64636261; l32 = 1'b0; cr32 = 1'b1;
        #1;
        chk("bp_ready_on_consume", rdy32, 1);
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("bp_consumed", cv32, 0);
        chk("bp_hold_crc", crc32o, 32'hCBF43926);
        send32(32'h00000065, 4'h1, 1'b1);
        q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        chk("b2b_valid", cv32, 1);
        chk("b2b_crc", crc32o, model(q));
        chk("b2b_cnt", cnt32, 5);
        @(posedge clk); #1;

        // reset mid-frame discards the partial frame
        send32(32'h34333231, 4'hF, 1'b0);
        send32(32'h38373635, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", cv32, 0);
        chk("mrst_crc", crc32o, 0);
        chk("mrst_cnt", cnt32, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send32(32'h34333231, 4'hF, 1'b0);
        chk("mrst_nospur0", cv32, 0);
        send32(32'h38373635, 4'hF, 1'b0);
        chk("mrst_nospur1", cv32, 0);
        send32(32'h00000039, 4'h1, 1'b1);
        chk("mrst_valid_end", cv32, 1);
        chk("mrst_crc_end", crc32o, 32'hCBF43926);
        chk("mrst_cnt_end", cnt32, 9);
        @(posedge clk); #1;

        // 64-bit check mode: "123456789" + FCS
        send64(64'h3837363534333231, 8'hFF, 1'b0);
        send64(64'h000000CBF4392639, 8'h1F, 1'b1);
        chk("chk_valid", cv64, 1);
        chk("chk_good", good64, 1);
        chk("chk_crc", crc64o, 32'h2144DF1C);
        chk("chk_cnt", cnt64, 13);
        chk("chk_err", err64, 0);
        send64(64'h3837363534333230, 8'hFF, 1'b0);
        send64(64'h000000CBF4392639, 8'h1F, 1'b1);
        q = '{8'h30, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        chk("chkbad_good", good64, 0);
        chk("chkbad_crc", crc64o, model(q));
        @(posedge clk); #1;

        // random frames with idle gaps against the byte-serial model
        for (int n = 0; n < 4; n++) begin
            len = $urandom_range(64, 1518);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            frame32(q, 1);
            chk($sformatf("rnd%0d_valid", n), cv32, 1);
            chk($sformatf("rnd%0d_crc", n), crc32o, model(q));
            chk($sformatf("rnd%0d_cnt", n), cnt32, 16'(len));
            chk($sformatf("rnd%0d_err", n), err32, 0);
            @(posedge clk); #1;
        end
        for (int n = 0; n < 2; n++) begin
            len = $urandom_range(64, 1518);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            f = model(q);
            for (int b = 0; b < 4; b++) q.push_back(f[8*b +: 8]);
            frame64(q, 1);
            chk($sformatf("rnd64_%0d_good", n), good64, 1);
            chk($sformatf("rnd64_%0d_crc", n), crc64o, 32'h2144DF1C);
            chk($sformatf("rnd64_%0d_cnt", n), cnt64, 16'(len + 4));
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
